// File: rtl/irq_dispatch_ctrl_if.sv
// rtl/irq_dispatch_ctrl_if.sv - valid/ack handshake between the dispatcher and its consumer
interface irq_dispatch_ctrl_if;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack;

  modport master (output irq_valid, output irq_id, input irq_ack);
  modport slave  (input irq_valid, input irq_id, output irq_ack);
endinterface

// File: rtl/irq_dispatch_ctrl.sv
// rtl/irq_dispatch_ctrl.sv - pending capture and one-at-a-time dispatch around a 4-to-2 priority encoder
module irq_dispatch_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8,
  parameter int LEVEL_MODE     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 req_in,
  output logic [3:0]                 pend_out,
  input  logic [1:0]                 enc_code,
  input  logic                       enc_valid,
  irq_dispatch_ctrl_if.master        irq_bus,
  output logic                       timeout_pulse,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         req_q, req_d;
  logic [3:0]         pend_q, pend_d;
  logic               irq_valid_q, irq_valid_d;
  logic [1:0]         irq_id_q, irq_id_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         set_vec;
  logic [3:0]         clr_vec;

  // A line already high when reset releases counts as an edge since req_q restarts at 0.
  assign set_vec = (LEVEL_MODE != 0) ? req_in : (req_in & ~req_q);

  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    clr_vec     = 4'b0000;
    req_d       = req_in;

    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          irq_id_d    = enc_code;
          irq_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Ack takes precedence over a coincident timeout.
        if (irq_bus.irq_ack) begin
          clr_vec     = 4'b0001 << irq_id_q;
          irq_valid_d = 1'b0;
          state_d     = GAP;
        end else if (cnt_q == CNT_LAST) begin
          clr_vec     = 4'b0001 << irq_id_q;
          irq_valid_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        irq_valid_d = 1'b0;
      end
    endcase

    // Set wins over a same-cycle clear so a re-raised line is never lost.
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 4'b0000;
      pend_q      <= 4'b0000;
      irq_valid_q <= 1'b0;
      irq_id_q    <= 2'b00;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pend_q      <= pend_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pend_out          = pend_q;
  assign irq_bus.irq_valid = irq_valid_q;
  assign irq_bus.irq_id    = irq_id_q;
  assign timeout_pulse     = timeout_q;
  assign busy              = (state_q == ISSUE) || (state_q == GAP);

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// tb/tb_irq_dispatch_ctrl.sv - directed stimulus with a cycle model and literal pins for irq_dispatch_ctrl
module tb_irq_dispatch_ctrl;

  localparam int T = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] pend_out;
  logic [1:0] enc_code;
  logic       enc_valid;
  logic       timeout_pulse;
  logic       busy;

  irq_dispatch_ctrl_if bus ();

  irq_dispatch_ctrl #(
    .TIMEOUT_CYCLES(T),
    .CNT_W(8),
    .LEVEL_MODE(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_in(req_in),
    .pend_out(pend_out),
    .enc_code(enc_code),
    .enc_valid(enc_valid),
    .irq_bus(bus.master),
    .timeout_pulse(timeout_pulse),
    .busy(busy)
  );

  // Reference 4-to-2 priority encoder fed by the pending register.
  always_comb begin
    enc_valid = |pend_out;
    enc_code  = 2'd0;
    for (int i = 0; i < 4; i++)
      if (pend_out[i]) enc_code = 2'(i);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a pending set, one outstanding offer with an age, and a cooldown.
  logic [3:0] m_pend, m_prev;
  logic       m_offering, m_tpulse;
  logic [1:0] m_id;
  int         m_age, m_cool;
  bit         cmp_en = 0;

  function automatic logic [1:0] top_bit(input logic [3:0] v);
    for (int i = 3; i >= 0; i--)
      if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    logic [3:0] setv, clr;
    if (rst) begin
      m_pend = 0; m_prev = 0; m_offering = 0; m_id = 0;
      m_age = 0; m_cool = 0; m_tpulse = 0;
    end else begin
      setv = req_in & ~m_prev;
      m_prev = req_in;
      clr = 0;
      m_tpulse = 0;
      if (m_offering) begin
        if (bus.irq_ack) begin
          clr = 4'b1 << m_id; m_offering = 0; m_cool = 1;
        end else if (m_age == T - 1) begin
          clr = 4'b1 << m_id; m_offering = 0; m_cool = 1; m_tpulse = 1;
        end else begin
          m_age++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (m_pend != 0) begin
        m_offering = 1; m_id = top_bit(m_pend); m_age = 0;
      end
      m_pend = (m_pend & ~clr) | setv;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pend", pend_out, m_pend);
      chk("model_valid", bus.irq_valid, m_offering);
      if (m_offering) chk("model_id", bus.irq_id, m_id);
      chk("model_tpulse", timeout_pulse, m_tpulse);
      chk("model_busy", busy, (m_offering || m_cool > 0) ? 1 : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int nvalid, npulse, nissue;

  initial begin
    rst = 1; req_in = 0; bus.irq_ack = 0;
    cyc();
    cmp_en = 1;
    cyc();
    rst = 0;
    chk("rst_pend", pend_out, 0);
    chk("rst_valid", bus.irq_valid, 0);
    chk("rst_id", bus.irq_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tpulse", timeout_pulse, 0);

    // Single edge
    req_in = 4'b0001; cyc();
    chk("single_pend", pend_out, 4'b0001);
    chk("single_valid_early", bus.irq_valid, 0);
    req_in = 0; cyc();
    chk("single_valid", bus.irq_valid, 1);
    chk("single_id", bus.irq_id, 0);
    bus.irq_ack = 1; cyc();
    chk("single_clr", pend_out, 0);
    chk("single_gap_valid", bus.irq_valid, 0);
    chk("single_gap_busy", busy, 1);
    bus.irq_ack = 0; cyc();
    chk("single_idle_busy", busy, 0);

    // Priority
    req_in = 4'b0101; cyc();
    req_in = 0; cyc();
    chk("prio_first", bus.irq_id, 2);
    bus.irq_ack = 1; cyc();
    chk("prio_pend_after1", pend_out, 4'b0001);
    bus.irq_ack = 0; cyc(); cyc();
    chk("prio_second_valid", bus.irq_valid, 1);
    chk("prio_second", bus.irq_id, 0);
    bus.irq_ack = 1; cyc();
    chk("prio_done", pend_out, 0);
    bus.irq_ack = 0; cyc(); cyc();

    // Timeout
    req_in = 4'b1000; cyc();
    req_in = 0;
    nvalid = 0; npulse = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.irq_valid) nvalid++;
      if (timeout_pulse) npulse++;
    end
    chk("to_valid_cycles", nvalid, T);
    chk("to_pulses", npulse, 1);
    chk("to_pend", pend_out, 0);

    // Ack and timeout in the same cycle
    req_in = 4'b1000; cyc();
    req_in = 0;
    cyc(); cyc(); cyc(); cyc();
    chk("col_valid_last", bus.irq_valid, 1);
    bus.irq_ack = 1; cyc();
    chk("col_no_pulse", timeout_pulse, 0);
    chk("col_pend", pend_out, 0);
    chk("col_valid", bus.irq_valid, 0);
    bus.irq_ack = 0; cyc(); cyc();

    // No preemption, set wins on re-pulse
    req_in = 4'b0010; cyc();
    req_in = 0; cyc();
    chk("np_id", bus.irq_id, 1);
    req_in = 4'b1000; cyc();
    req_in = 0; cyc();
    chk("np_id_frozen", bus.irq_id, 1);
    chk("np_pend", pend_out, 4'b1010);
    bus.irq_ack = 1; req_in = 4'b0010; cyc();
    chk("np_setwins", pend_out, 4'b1010);
    bus.irq_ack = 0; req_in = 0; cyc(); cyc();
    chk("np_next_id", bus.irq_id, 3);
    bus.irq_ack = 1; cyc();
    chk("np_pend_after", pend_out, 4'b0010);
    bus.irq_ack = 0; cyc(); cyc();
    chk("np_reoffer", bus.irq_id, 1);
    chk("np_reoffer_valid", bus.irq_valid, 1);
    bus.irq_ack = 1; cyc();
    bus.irq_ack = 0; cyc(); cyc();
    chk("np_empty", pend_out, 0);

    // Reset mid-handshake, then a line held through reset release
    req_in = 4'b0100; cyc();
    req_in = 0; cyc();
    chk("rr_valid_before", bus.irq_valid, 1);
    rst = 1; req_in = 4'b0010; cyc();
    chk("rr_pend", pend_out, 0);
    chk("rr_valid", bus.irq_valid, 0);
    chk("rr_busy", busy, 0);
    chk("rr_tpulse", timeout_pulse, 0);
    chk("rr_id", bus.irq_id, 0);
    cyc();
    rst = 0; cyc();
    chk("rr_edge_pend", pend_out, 4'b0010);
    nissue = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.irq_valid) begin
        nissue++;
        chk("rr_issue_id", bus.irq_id, 1);
        bus.irq_ack = 1;
      end else begin
        bus.irq_ack = 0;
      end
      cyc();
    end
    chk("rr_issue_count", nissue, 1);
    bus.irq_ack = 0; req_in = 0; cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/irq_dispatch_ctrl.md
Name: irq_dispatch_ctrl

Overview:
- Sequential front/back end for the 4-to-2 priority encoder.
- Captures four request lines into a pending register and drives that register into the encoder's 4-bit input.
- Consumes the encoder's 2-bit code and valid flag, then issues one request at a time to a consumer using a valid/ack handshake.
- Clears the serviced pending bit on ack, or on timeout if the consumer never acks.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles irq_valid is held without ack before the request is dropped; legal range 2..2^CNT_W.
- CNT_W, 8: width of the timeout counter.
- LEVEL_MODE, 0: 0 = pending bit set on rising edge of req_in; 1 = pending bit set whenever req_in is high.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_in  in  4  raw request lines, already synchronous to clk; bit 3 is highest priority.
- pend_out  out  4  registered pending vector; drives the encoder's in[3:0].
- enc_code  in  2  encoder out[1:0], a combinational function of pend_out.
- enc_valid  in  1  encoder valid; high iff pend_out != 0.
- irq_valid  out  1  request offered to consumer.
- irq_id  out  2  index of the offered request; stable while irq_valid=1.
- irq_ack  in  1  consumer accepts; sampled only while irq_valid=1.
- timeout_pulse  out  1  one-cycle pulse when an offered request is dropped.
- busy  out  1  high in states ISSUE and GAP.

Behaviour:
- Reset (sync, rst=1 at an edge) sets: pending=0, req_q=0, state=IDLE, irq_valid=0, irq_id=0, timeout_pulse=0, busy=0, cnt=0.
- Reset mid-handshake aborts silently: no timeout_pulse, all pending requests are lost.
- Edge detect: req_q <= req_in every cycle. set_vec = req_in & ~req_q (LEVEL_MODE=0) or req_in (LEVEL_MODE=1).
- Because req_q resets to 0, a line that is high when reset deasserts counts as an edge on the first cycle.
- Pending update: pending <= (pending & ~clr_vec) | set_vec. Set wins if the same bit is set and cleared in one cycle.
- FSM states:
  - IDLE: if enc_valid, then irq_id <= enc_code, irq_valid <= 1, cnt <= 0, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: irq_id is frozen and new pending bits do not preempt.
    - If irq_ack: clr_vec = onehot(irq_id), irq_valid <= 0, go to GAP.
    - Else if cnt == TIMEOUT_CYCLES-1: clr_vec = onehot(irq_id), irq_valid <= 0, timeout_pulse <= 1, go to GAP.
    - Else: cnt <= cnt+1.
    - Ack and timeout in the same cycle: ack wins, no pulse.
  - GAP: exactly one cycle, so the encoder output settles on the updated pending_out; timeout_pulse <= 0; go to IDLE.
- Latency, rise path: req_in rises before edge k → pending bit visible after edge k → irq_valid high after edge k+1.
- Latency, completion path: ack sampled at edge m → irq_valid low after m → earliest next irq_valid after edge m+2.
- irq_valid stays high for at most TIMEOUT_CYCLES cycles.
- irq_ack outside ISSUE is ignored.
- enc_code is used only when enc_valid=1. The block trusts the encoder: the selected bit is the highest set bit of pend_out.
- Throughput: at most one request per 3 cycles (IDLE, ISSUE with immediate ack, GAP).

Test Plan:
- Single edge: req_in=0001 for 1 cycle after reset → pend_out=0001 next cycle, then irq_valid=1 with irq_id=00. Ack in the first ISSUE cycle → pend_out=0000, irq_valid=0, busy=1 for one GAP cycle, then idle.
- Priority: req_in=0101 pulsed once → irq_id=10 first. Ack → after GAP, irq_id=00. Ack → pend_out=0000.
- Timeout: TIMEOUT_CYCLES=4, req_in=1000 pulse, never ack → irq_valid high exactly 4 cycles, timeout_pulse=1 for 1 cycle, pend_out=0000.
- Ack vs timeout collision: ack on cycle 4 with TIMEOUT_CYCLES=4 → no timeout_pulse, normal clear.
- No preemption / set-wins: while irq_id=01 is offered, pulse req_in[3] → irq_id stays 01 until ack, then 11 is offered. Re-pulse req_in[1] in the ack cycle → bit 1 remains pending and is re-offered.
- Reset: rst during ISSUE → next cycle all outputs are 0 and pending=0. req_in=0010 held high through reset release → with LEVEL_MODE=0, exactly one request id=01 is issued.
